sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter: TIMEOUT_CYCLES, 1024, max cycles a grant waits for s_ready (used only with ARB_TIMEOUT_EN).
REQ-002 SHALL have port: clk  input  1  clock, all logic posedge.
REQ-003 SHALL have port: resetn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: m0_valid / m1_valid  input  1  master request, held until the matching ready.
REQ-005 SHALL have ports: m0_addr / m1_addr  input  32  byte address.
REQ-006 SHALL have ports: m0_wdata / m1_wdata  input  32  write data.
REQ-007 SHALL have ports: m0_wstrb / m1_wstrb  input  4  byte write mask; 0 = read.
REQ-008 SHALL have ports: m0_ready / m1_ready  output  1  one-cycle completion pulse.
REQ-009 SHALL have ports: m0_rdata / m1_rdata  output  32  read data, valid while ready is high.
REQ-010 SHALL have ports: m0_fault / m1_fault  output  1  timeout pulse, coincident with ready.
REQ-011 SHALL have port: s_valid  output  1  request to the SDRAM controller.
REQ-012 SHALL have ports: s_addr  output  32, s_wdata  output  32, s_wstrb  output  4  muxed from the granted master.
REQ-013 SHALL have port: s_ready  input  1  controller completion pulse.
REQ-014 SHALL have port: s_rdata  input  32  controller read data.

Function
REQ-015 SHALL implement FSM states IDLE, GRANT0, GRANT1, plus a 1-bit last_grant register.
REQ-016 In IDLE, SHALL handle requests as follows:
- only m0_valid -> GRANT0;
- only m1_valid -> GRANT1;
- both -> grant the master not equal to last_grant;
- neither -> stay in IDLE.
REQ-017 SHALL keep s_valid low in IDLE; arbitration adds exactly one cycle of latency.
REQ-018 In GRANTx, SHALL drive s_valid = mx_valid && !s_ready, and drive s_addr/s_wdata/s_wstrb from master x combinationally.
REQ-019 In GRANTx, on s_ready: mx_ready=1 for that cycle, mx_rdata=s_rdata, last_grant<=x, next state IDLE.
REQ-020 Outside grant completion, SHALL hold mx_ready=0 and mx_rdata=0; the non-granted master never sees ready.
REQ-021 SHALL let a granted master that deasserts valid before s_ready return the FSM to IDLE next cycle with no ready pulse.
REQ-022 SHALL ignore s_ready in IDLE (stray pulse): no master ready.
REQ-023 SHALL apply round-robin fairness: two masters with continuous requests alternate grants, each waiting at most one transaction.
REQ-024 SHALL drive s_addr, s_wdata and s_wstrb to 0 in IDLE.

Reset
REQ-025 While resetn=0, SHALL force: state IDLE, last_grant=1 (m0 wins the first tie), all ready/fault/s_valid outputs 0, timeout counter 0.
REQ-026 On reset during GRANTx, SHALL drive s_valid low the cycle after resetn sampled low and issue no ready pulse.

Configuration
REQ-027 SHALL gate the timeout feature with macro ARB_TIMEOUT_EN.
REQ-028 With ARB_TIMEOUT_EN defined, a counter SHALL:
- clear on entry to GRANTx and increment each GRANTx cycle;
- on reaching TIMEOUT_CYCLES-1 without s_ready, pulse mx_ready and mx_fault together with mx_rdata=0, then return to IDLE with last_grant<=x;
- give s_ready priority if it arrives in that same cycle (normal completion, fault=0).
REQ-029 Without ARB_TIMEOUT_EN, SHALL omit the counter, tie m0_fault/m1_fault to 0, and hold GRANTx indefinitely.

Verification
REQ-030 Bench SHALL cover: m0 read 0x8000_0000, s_ready 3 cycles after s_valid, s_rdata=0x1234_5678 -> m0_ready pulse with m0_rdata=0x1234_5678; m1_ready stays 0.
REQ-031 Bench SHALL cover: m0 and m1 valid in the same cycle after reset -> GRANT0 first, then GRANT1; the next simultaneous pair -> GRANT0 again (alternation).
REQ-032 Bench SHALL cover: m1 write, wstrb=4'b0011, wdata=0xAABB_CCDD -> s_wstrb=0011, s_wdata=0xAABB_CCDD on s_valid; s_valid low in the s_ready cycle.
REQ-033 Bench SHALL cover: resetn low two cycles into GRANT0 -> s_valid=0 next cycle, no m0_ready; after release, a fresh m0 request completes normally.
REQ-034 Bench SHALL cover, with ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: s_ready never asserted -> m0_ready and m0_fault pulse 15 cycles after GRANT0 entry, m0_rdata=0; a later stray s_ready is ignored.
REQ-035 Bench SHALL cover: stray s_ready in IDLE with no requests -> m0_ready=m1_ready=0, state stays IDLE.

Source files
------------

// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Two-master, round-robin arbiter in front of a single SDRAM controller
//   port. One request is in flight at a time. An IDLE cycle between
//   grants performs the arbitration, so a request reaches the controller
//   one cycle after it is raised.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     Defined   : a grant that waits TIMEOUT_CYCLES cycles for s_ready is
//                 terminated with a ready+fault pulse and rdata=0.
//     Undefined : no counter; m0_fault/m1_fault tie to 0 and a grant is
//                 held until s_ready or until the master drops valid.
//
//   Handshake: a master raises mX_valid with stable addr/wdata/wstrb and
//   holds it until the single-cycle mX_ready pulse. mX_rdata and mX_fault
//   are meaningful only while mX_ready is high and read 0 otherwise. On
//   the controller side s_valid is high while the request is pending and
//   s_ready is a single-cycle completion pulse; s_valid falls in the
//   s_ready cycle. A master that drops valid before completion abandons
//   the request and never sees ready.
//
//   Ports
//     clk, resetn              clock (posedge), synchronous active-low reset
//     m0_* / m1_*              master request (valid/addr/wdata/wstrb in,
//                              ready/rdata/fault out); wstrb=0 is a read
//     s_valid/s_addr/s_wdata/s_wstrb   request to the controller
//     s_ready/s_rdata          controller completion and read data
//     dbg_state_o              current FSM state (0 IDLE, 1 GRANT0, 2 GRANT1)
//     dbg_last_grant_o         master granted most recently
//     dbg_tmo_cnt_o            timeout counter (0 when the feature is off)
module sdram_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  output logic        m0_fault,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        m1_fault,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  dbg_state_o,
  output logic        dbg_last_grant_o,
  output logic [$clog2(TIMEOUT_CYCLES+1)-1:0] dbg_tmo_cnt_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   last_grant_q, last_grant_d;
  logic   tmo;  // grant has waited its full budget this cycle

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tmo           = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign dbg_tmo_cnt_o = cnt_q;
`else
  assign tmo           = 1'b0;
  assign dbg_tmo_cnt_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;  // m0 wins the first tie after reset
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    s_valid      = 1'b0;
    s_addr       = '0;
    s_wdata      = '0;
    s_wstrb      = '0;
    m0_ready     = 1'b0;
    m0_rdata     = '0;
    m0_fault     = 1'b0;
    m1_ready     = 1'b0;
    m1_rdata     = '0;
    m1_fault     = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d        = '0;  // every grant is entered from IDLE, so this clears it
`endif

    case (state_q)
      IDLE: begin
        // s_ready here is a stray pulse and is deliberately ignored.
        if (m0_valid && m1_valid) begin
          state_d = last_grant_q ? GRANT0 : GRANT1;
        end else if (m0_valid) begin
          state_d = GRANT0;
        end else if (m1_valid) begin
          state_d = GRANT1;
        end
      end

      GRANT0: begin
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
        s_wstrb = m0_wstrb;
        s_valid = m0_valid && !s_ready;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q + CNT_W'(1);
`endif
        // s_ready outranks the timeout when both land in the same cycle.
        if (!m0_valid) begin
          state_d = IDLE;
        end else if (s_ready) begin
          m0_ready     = 1'b1;
          m0_rdata     = s_rdata;
          last_grant_d = 1'b0;
          state_d      = IDLE;
        end else if (tmo) begin
          m0_ready     = 1'b1;
          m0_fault     = 1'b1;
          last_grant_d = 1'b0;
          state_d      = IDLE;
        end
      end

      GRANT1: begin
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
        s_wstrb = m1_wstrb;
        s_valid = m1_valid && !s_ready;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = cnt_q + CNT_W'(1);
`endif
        if (!m1_valid) begin
          state_d = IDLE;
        end else if (s_ready) begin
          m1_ready     = 1'b1;
          m1_rdata     = s_rdata;
          last_grant_d = 1'b1;
          state_d      = IDLE;
        end else if (tmo) begin
          m1_ready     = 1'b1;
          m1_fault     = 1'b1;
          last_grant_d = 1'b1;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // While reset is asserted the grant may still be registered; suppress
    // every output so the controller and masters see nothing in that cycle.
    if (!resetn) begin
      s_valid  = 1'b0;
      s_addr   = '0;
      s_wdata  = '0;
      s_wstrb  = '0;
      m0_ready = 1'b0;
      m0_rdata = '0;
      m0_fault = 1'b0;
      m1_ready = 1'b0;
      m1_rdata = '0;
      m1_fault = 1'b0;
    end
  end

  assign dbg_state_o      = state_q;
  assign dbg_last_grant_o = last_grant_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Testbench for sdram_arbiter. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled on the falling edge. Every completion
// the bench expects is pushed to exp_q as {master, fault, rdata} when the
// request is driven; a falling-edge monitor pops and compares on every
// ready pulse and flags any ready that nothing asked for.
module tb_sdram_arbiter;

  localparam int unsigned TMO = 16;
  localparam int W = 34;

  logic        clk;
  logic        resetn;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready, m0_fault, m1_fault;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid, s_ready;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [3:0]  s_wstrb;
  logic [1:0]  dbg_state;
  logic        dbg_last_grant;
  logic [$clog2(TMO+1)-1:0] dbg_tmo_cnt;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_last;

  sdram_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn),
    .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_ready(m0_ready), .m0_rdata(m0_rdata), .m0_fault(m0_fault),
    .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_ready(m1_ready), .m1_rdata(m1_rdata), .m1_fault(m1_fault),
    .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_ready(s_ready), .s_rdata(s_rdata),
    .dbg_state_o(dbg_state), .dbg_last_grant_o(dbg_last_grant), .dbg_tmo_cnt_o(dbg_tmo_cnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    resetn   = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;
    repeat (2) tick();
    resetn   = 1'b1;
    exp_last = 1'b1;
  endtask

  // ---------------- drivers ----------------
  task automatic drive_m(input int m, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb);
    if (m == 0) begin
      m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb;
    end else begin
      m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb;
    end
  endtask

  // Controller model: wait for s_valid, check the muxed request, answer
  // lat cycles later, then the served master m drops its request.
  task automatic serve(input int m, input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                       input logic [3:0] exp_wstrb, input logic [31:0] rdata,
                       input int lat, output int waited);
    waited = 0;
    @(negedge clk);
    while (!s_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (s_valid !== 1'b1) begin
      $display("FAIL serve_wait: s_valid=%b after %0d cycles, required 1", s_valid, waited);
      failures++;
      if (m == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
      return;
    end
    checks++;
    if ({s_addr, s_wdata, s_wstrb} !== {exp_addr, exp_wdata, exp_wstrb}) begin
      $display("FAIL serve_req: addr=%h wdata=%h wstrb=%b, required addr=%h wdata=%h wstrb=%b",
               s_addr, s_wdata, s_wstrb, exp_addr, exp_wdata, exp_wstrb);
      failures++;
    end
    repeat (lat) @(posedge clk);
    #1;
    s_ready = 1'b1;
    s_rdata = rdata;
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0) begin
      $display("FAIL serve_svalid_drop: s_valid=%b in s_ready cycle, required 0", s_valid);
      failures++;
    end
    tick();
    s_ready = 1'b0;
    s_rdata = '0;
    if (m == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    checks++;
    if ((!m0_ready && (m0_rdata !== 32'h0 || m0_fault !== 1'b0)) ||
        (!m1_ready && (m1_rdata !== 32'h0 || m1_fault !== 1'b0))) begin
      $display("FAIL idle_outputs: m0_rdata=%h m0_fault=%b m1_rdata=%h m1_fault=%b, required 0",
               m0_rdata, m0_fault, m1_rdata, m1_fault);
      failures++;
    end
    if (m0_ready === 1'b1 || m1_ready === 1'b1) begin
      got = m1_ready ? {1'b1, m1_fault, m1_rdata} : {1'b0, m0_fault, m0_rdata};
      checks++;
      if (m0_ready === 1'b1 && m1_ready === 1'b1) begin
        $display("FAIL both_ready: m0_ready=1 m1_ready=1, required at most one");
        failures++;
      end else if (exp_q.size() == 0) begin
        $display("FAIL unexpected_ready: got {m,fault,rdata}=%h, required no ready", got);
        failures++;
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          $display("FAIL completion: got {m,fault,rdata}=%h, required %h", got, exp);
          failures++;
        end
      end
    end
  end

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn   = 1'b0;
    m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    s_ready  = 1'b0; s_rdata = '0;
    repeat (2) tick();
    @(negedge clk);
    checks++;
    if ({s_valid, m0_ready, m1_ready, m0_fault, m1_fault} !== 5'b0) begin
      $display("FAIL reset_outputs: {s_valid,r0,r1,f0,f1}=%b, required 00000",
               {s_valid, m0_ready, m1_ready, m0_fault, m1_fault});
      failures++;
    end
    checks++;
    if ({dbg_state, dbg_last_grant} !== 3'b001) begin
      $display("FAIL reset_state: state=%0d last_grant=%b, required 0 and 1", dbg_state, dbg_last_grant);
      failures++;
    end
    tick();
    resetn   = 1'b1;
    exp_last = 1'b1;
  endtask

  task automatic test_basic_read();
    int w;
    tick();
    drive_m(0, 32'h8000_0000, 32'h0, 4'b0000);
    exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
    @(negedge clk);
    checks++;
    if ({s_valid, dbg_state} !== 3'b000 || {s_addr, s_wdata, s_wstrb} !== 68'h0) begin
      $display("FAIL read_idle_cycle: s_valid=%b state=%0d s_addr=%h, required 0 0 0",
               s_valid, dbg_state, s_addr);
      failures++;
    end
    serve(0, 32'h8000_0000, 32'h0, 4'b0000, 32'h1234_5678, 3, w);
    checks++;
    if (w !== 0) begin
      $display("FAIL read_latency: extra wait=%0d, required 0", w);
      failures++;
    end
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || exp_q.size() != 0) begin
      $display("FAIL read_done: state=%0d pending=%0d, required 0 0", dbg_state, exp_q.size());
      failures++;
    end
  endtask

  task automatic test_alternation();
    int w;
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      drive_m(0, 32'h0000_0100 + 32'(r), 32'h0, 4'b0000);
      drive_m(1, 32'h0000_0200 + 32'(r), 32'h0, 4'b0000);
      exp_q.push_back({1'b0, 1'b0, 32'hA0A0_0000 + 32'(r)});
      exp_q.push_back({1'b1, 1'b0, 32'hB0B0_0000 + 32'(r)});
      serve(0, 32'h0000_0100 + 32'(r), 32'h0, 4'b0000, 32'hA0A0_0000 + 32'(r), 1, w);
      serve(1, 32'h0000_0200 + 32'(r), 32'h0, 4'b0000, 32'hB0B0_0000 + 32'(r), 2, w);
      checks++;
      if (w !== 1) begin
        $display("FAIL alt_rearb_latency: wait=%0d, required 1", w);
        failures++;
      end
      tick();
    end
  endtask

  task automatic test_write();
    int w;
    tick();
    drive_m(1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0011);
    exp_q.push_back({1'b1, 1'b0, 32'hDEAD_0000});
    serve(1, 32'h0000_0040, 32'hAABB_CCDD, 4'b0011, 32'hDEAD_0000, 2, w);
    checks++;
    if (w !== 1) begin
      $display("FAIL write_latency: wait=%0d, required 1", w);
      failures++;
    end
  endtask

  task automatic test_reset_in_grant();
    int w;
    tick();
    drive_m(0, 32'h0000_0300, 32'h0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b1 || dbg_state !== 2'd1) begin
      $display("FAIL rst_grant_entry: s_valid=%b state=%0d, required 1 1", s_valid, dbg_state);
      failures++;
    end
    tick();
    tick();
    resetn  = 1'b0;
    s_ready = 1'b1;
    s_rdata = 32'hBAD0_BAD0;
    @(negedge clk);
    checks++;
    if ({s_valid, m0_ready} !== 2'b00) begin
      $display("FAIL rst_in_grant: s_valid=%b m0_ready=%b, required 0 0", s_valid, m0_ready);
      failures++;
    end
    tick();
    s_ready  = 1'b0;
    s_rdata  = '0;
    m0_valid = 1'b0;
    resetn   = 1'b1;
    exp_last = 1'b1;
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL rst_after: s_valid=%b state=%0d, required 0 0", s_valid, dbg_state);
      failures++;
    end
    tick();
    drive_m(0, 32'h0000_0304, 32'h0, 4'b0000);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_C0DE});
    serve(0, 32'h0000_0304, 32'h0, 4'b0000, 32'h0000_C0DE, 1, w);
    checks++;
    if (w !== 1) begin
      $display("FAIL rst_fresh_latency: wait=%0d, required 1", w);
      failures++;
    end
  endtask

  task automatic test_timeout();
`ifdef ARB_TIMEOUT_EN
    int idx;
    tick();
    drive_m(0, 32'h0000_0500, 32'h0, 4'b0000);
    s_rdata = 32'hFFFF_FFFF;
    exp_q.push_back({1'b0, 1'b1, 32'h0});
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b1) begin
      $display("FAIL tmo_entry: s_valid=%b, required 1", s_valid);
      failures++;
    end
    idx = 0;
    while (m0_ready !== 1'b1 && idx < 40) begin
      @(negedge clk);
      idx++;
    end
    checks++;
    if (idx != int'(TMO) - 1) begin
      $display("FAIL tmo_cycle: fault after %0d cycles, required %0d", idx, TMO - 1);
      failures++;
    end
    tick();
    m0_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0) begin
      $display("FAIL tmo_idle: state=%0d, required 0", dbg_state);
      failures++;
    end
    tick();
    s_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({m0_ready, m1_ready} !== 2'b00) begin
      $display("FAIL tmo_stray: m0_ready=%b m1_ready=%b, required 0 0", m0_ready, m1_ready);
      failures++;
    end
    tick();
    s_ready = 1'b0;
    s_rdata = '0;
`else
    int bad;
    int w;
    tick();
    drive_m(0, 32'h0000_0500, 32'h0, 4'b0000);
    exp_q.push_back({1'b0, 1'b0, 32'h0000_0099});
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (s_valid !== 1'b1 || m0_ready !== 1'b0 || m0_fault !== 1'b0 || dbg_state !== 2'd1) bad++;
    end
    checks++;
    if (bad != 0) begin
      $display("FAIL hold_grant: %0d bad cycles, required 0", bad);
      failures++;
    end
    serve(0, 32'h0000_0500, 32'h0, 4'b0000, 32'h0000_0099, 1, w);
    checks++;
    if (w !== 0) begin
      $display("FAIL hold_serve: wait=%0d, required 0", w);
      failures++;
    end
`endif
  endtask

  task automatic test_stray_ready();
    tick();
    s_ready = 1'b1;
    s_rdata = 32'h5555_5555;
    @(negedge clk);
    checks++;
    if ({m0_ready, m1_ready, s_valid} !== 3'b000 || dbg_state !== 2'd0) begin
      $display("FAIL stray_ready: r0=%b r1=%b s_valid=%b state=%0d, required 0 0 0 0",
               m0_ready, m1_ready, s_valid, dbg_state);
      failures++;
    end
    tick();
    s_ready = 1'b0;
    s_rdata = '0;
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0) begin
      $display("FAIL stray_state: state=%0d, required 0", dbg_state);
      failures++;
    end
  endtask

  task automatic test_abandon();
    tick();
    drive_m(1, 32'h0000_0600, 32'h0, 4'b0000);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd2 || s_valid !== 1'b1) begin
      $display("FAIL abandon_grant: state=%0d s_valid=%b, required 2 1", dbg_state, s_valid);
      failures++;
    end
    tick();
    m1_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (s_valid !== 1'b0) begin
      $display("FAIL abandon_svalid: s_valid=%b, required 0", s_valid);
      failures++;
    end
    tick();
    @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0) begin
      $display("FAIL abandon_idle: state=%0d, required 0", dbg_state);
      failures++;
    end
  endtask

  task automatic test_back_to_back();
    int w, pat, lat, f, s;
    logic [31:0] a0, a1, d0, d1;
    apply_reset();
    for (int i = 0; i < 10; i++) begin
      pat = $urandom_range(0, 2);
      lat = $urandom_range(1, 4);
      a0 = {$urandom_range(0, 32'hFFFF), 16'h0000};
      a1 = {$urandom_range(0, 32'hFFFF), 16'h0004};
      d0 = $urandom;
      d1 = $urandom;
      if (pat < 2) begin
        drive_m(pat, pat == 0 ? a0 : a1, 32'h0, 4'b0000);
        exp_q.push_back({pat[0], 1'b0, d0});
        serve(pat, pat == 0 ? a0 : a1, 32'h0, 4'b0000, d0, lat, w);
        exp_last = pat[0];
      end else begin
        f = exp_last ? 0 : 1;
        s = 1 - f;
        drive_m(0, a0, 32'h0, 4'b0000);
        drive_m(1, a1, 32'h0, 4'b0000);
        exp_q.push_back({f[0], 1'b0, d0});
        exp_q.push_back({s[0], 1'b0, d1});
        exp_q.push_back({f[0], 1'b0, ~d0});
        serve(f, f == 0 ? a0 : a1, 32'h0, 4'b0000, d0, lat, w);
        // Winner re-requests at once; the other master must go next.
        drive_m(f, (f == 0 ? a0 : a1) + 32'h10, 32'h0, 4'b0000);
        serve(s, s == 0 ? a0 : a1, 32'h0, 4'b0000, d1, lat, w);
        serve(f, (f == 0 ? a0 : a1) + 32'h10, 32'h0, 4'b0000, ~d0, 1, w);
        exp_last = f[0];
      end
      checks++;
      if (dbg_last_grant !== exp_last) begin
        $display("FAIL b2b_last_grant: iter %0d last_grant=%b, required %b", i, dbg_last_grant, exp_last);
        failures++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_basic_read();
    test_alternation();
    test_write();
    test_reset_in_grant();
    test_timeout();
    test_stray_ready();
    test_abandon();
    test_back_to_back();
    repeat (3) tick();
    checks++;
    if (exp_q.size() != 0) begin
      $display("FAIL pending_at_end: %0d completions missing, required 0", exp_q.size());
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
